// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core: load-use bubble insertion,
// data-memory latency freeze, taken-branch IF/ID flush and a saturating stall counter.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16,
    parameter int SKIP_R0 = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              ifid_rs_used_i,
    input  logic              ifid_rt_used_i,
    input  logic              idex_memrd_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic              exmem_memop_i,
    input  logic              branch_taken_i,
    input  logic              cnt_clr_i,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              pipe_freeze_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
    localparam logic              HAS_LAT   = (MEM_LAT > 0);
    localparam logic              SKIP_ZERO = (SKIP_R0 != 0);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_nxt_s;
    logic              freeze_s;
    logic              lu_s;
    logic              rs_hit_s;
    logic              rt_hit_s;
    logic              r0_dest_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    // Load-use detection against the load destination sitting in EX.
    always_comb begin
        rs_hit_s  = ifid_rs_used_i & (idex_rt_i == ifid_rs_i);
        rt_hit_s  = ifid_rt_used_i & (idex_rt_i == ifid_rt_i);
        r0_dest_s = SKIP_ZERO & (idex_rt_i == REG_ZERO);
        lu_s      = idex_memrd_i & ~r0_dest_s & (rs_hit_s | rt_hit_s);
    end

    // Memory-wait FSM state register; reset aborts any pending freeze.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_RUN;
            wcnt_r  <= WCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
        end
    end

    // Memory-wait FSM next state: the access entering MEM counts as the first frozen cycle.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        case (state_r)
            ST_RUN: begin
                if (HAS_LAT && exmem_memop_i) begin
                    state_nxt_s = ST_WAIT;
                    wcnt_nxt_s  = WCNT_INIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (wcnt_r != WCNT_ZERO) begin
                    wcnt_nxt_s = wcnt_r - WCNT_ONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                wcnt_nxt_s  = WCNT_ZERO;
            end
        endcase
    end

    // Memory-wait FSM output: freeze while the access is still being served.
    always_comb begin
        case (state_r)
            ST_RUN:  freeze_s = HAS_LAT & exmem_memop_i;
            ST_WAIT: freeze_s = (wcnt_r != WCNT_ZERO);
            default: freeze_s = 1'b0;
        endcase
    end

    // Priority resolution freeze > load-use > branch; everything quiet while in reset.
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        if (!rst_i) begin
            pc_stall_o = 1'b0;
        end else if (freeze_s) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            pipe_freeze_o = 1'b1;
        end else if (lu_s) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end else begin
            pc_stall_o = 1'b0;
        end
    end

    // Saturating count of PC-stall cycles; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (pc_stall_o && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl: three parameter sets driven in parallel and
// checked every cycle against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

    localparam int NI = 3;
    localparam int P_LAT [NI] = '{3, 1, 0};
    localparam int P_CW  [NI] = '{4, 16, 8};
    localparam int P_SK  [NI] = '{1, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs = 5'd0, rt = 5'd0, idex_rt = 5'd0;
    logic       rs_used = 1'b0, rt_used = 1'b0, memrd = 1'b0, memop = 1'b0, br = 1'b0, clr = 1'b0;

    logic        pcs0, ifs0, fl0, bub0, frz0;
    logic        pcs1, ifs1, fl1, bub1, frz1;
    logic        pcs2, ifs2, fl2, bub2, frz2;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;
    logic [7:0]  cnt2;
    logic [4:0]  ctl  [NI];
    int unsigned cntv [NI];

    assign ctl[0] = {pcs0, ifs0, fl0, bub0, frz0};
    assign ctl[1] = {pcs1, ifs1, fl1, bub1, frz1};
    assign ctl[2] = {pcs2, ifs2, fl2, bub2, frz2};
    assign cntv[0] = 32'(cnt0);
    assign cntv[1] = 32'(cnt1);
    assign cntv[2] = 32'(cnt2);

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .CNT_W(4), .SKIP_R0(1)) u0 (
        .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt),
        .ifid_rs_used_i(rs_used), .ifid_rt_used_i(rt_used), .idex_memrd_i(memrd),
        .idex_rt_i(idex_rt), .exmem_memop_i(memop), .branch_taken_i(br), .cnt_clr_i(clr),
        .pc_stall_o(pcs0), .ifid_stall_o(ifs0), .ifid_flush_o(fl0), .idex_bubble_o(bub0),
        .pipe_freeze_o(frz0), .stall_cnt_o(cnt0));

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16), .SKIP_R0(0)) u1 (
        .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt),
        .ifid_rs_used_i(rs_used), .ifid_rt_used_i(rt_used), .idex_memrd_i(memrd),
        .idex_rt_i(idex_rt), .exmem_memop_i(memop), .branch_taken_i(br), .cnt_clr_i(clr),
        .pc_stall_o(pcs1), .ifid_stall_o(ifs1), .ifid_flush_o(fl1), .idex_bubble_o(bub1),
        .pipe_freeze_o(frz1), .stall_cnt_o(cnt1));

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(0), .CNT_W(8), .SKIP_R0(1)) u2 (
        .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt),
        .ifid_rs_used_i(rs_used), .ifid_rt_used_i(rt_used), .idex_memrd_i(memrd),
        .idex_rt_i(idex_rt), .exmem_memop_i(memop), .branch_taken_i(br), .cnt_clr_i(clr),
        .pc_stall_o(pcs2), .ifid_stall_o(ifs2), .ifid_flush_o(fl2), .idex_bubble_o(bub2),
        .pipe_freeze_o(frz2), .stall_cnt_o(cnt2));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: per-instance access tracking and stall count.
    bit m_busy [NI];
    int m_done [NI];
    int m_cnt  [NI];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_lu(input int sk);
        bit r0_skip;
        r0_skip = (sk != 0) && (idex_rt == 5'd0);
        return memrd && !r0_skip && ((rs_used && idex_rt == rs) || (rt_used && idex_rt == rt));
    endfunction

    // One clock: check outputs mid-cycle, advance the model, move past the rising edge.
    task automatic step();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            bit        ef;
            logic [4:0] exp_ctl;
            if (!rst) begin
                m_busy[g] = 1'b0;
                m_done[g] = 0;
                m_cnt[g]  = 0;
                exp_ctl   = 5'b00000;
            end else begin
                if (!m_busy[g]) ef = (P_LAT[g] > 0) && memop;
                else            ef = (m_done[g] < P_LAT[g]);
                if (ef)            exp_ctl = 5'b11001;
                else if (m_lu(P_SK[g])) exp_ctl = 5'b11010;
                else if (br)       exp_ctl = 5'b00100;
                else               exp_ctl = 5'b00000;
            end
            check($sformatf("ctl%0d", g), 32'(ctl[g]), 32'(exp_ctl));
            check($sformatf("cnt%0d", g), cntv[g], m_cnt[g]);
            if (rst) begin
                if (!m_busy[g]) begin
                    if ((P_LAT[g] > 0) && memop) begin
                        m_busy[g] = 1'b1;
                        m_done[g] = 1;
                    end
                end else if (m_done[g] < P_LAT[g]) begin
                    m_done[g]++;
                end else begin
                    m_busy[g] = 1'b0;
                end
                if (clr) m_cnt[g] = 0;
                else if (exp_ctl[4] && m_cnt[g] < (2 ** P_CW[g]) - 1) m_cnt[g]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs = 5'd0; rt = 5'd0; idex_rt = 5'd0; rs_used = 1'b0; rt_used = 1'b0;
        memrd = 1'b0; memop = 1'b0; br = 1'b0; clr = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            m_busy[g] = 1'b0; m_done[g] = 0; m_cnt[g] = 0;
        end
        idle();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();

        // lw $5 followed by a reader of $5, then the bubble clears the load
        memrd = 1'b1; idex_rt = 5'd5; rs = 5'd5; rs_used = 1'b1;
        step();
        memrd = 1'b0;
        step();
        // $0 destination, and an rt match that the instruction does not read
        memrd = 1'b1; idex_rt = 5'd0; rs = 5'd0; rs_used = 1'b1;
        step();
        idex_rt = 5'd7; rt = 5'd7; rs = 5'd1; rt_used = 1'b0;
        step();
        idle();

        // Memory freeze with exmem_memop held: exactly three stalls on u0
        clr = 1'b1;
        step();
        clr = 1'b0;
        memop = 1'b1;
        repeat (4) step();
        check("frz_cnt", cntv[0], 32'd3);
        memop = 1'b0;
        step();

        // Freeze, load-use and branch together, then lu after thaw, then flush
        memop = 1'b1; br = 1'b1; memrd = 1'b1; idex_rt = 5'd9; rt = 5'd9; rt_used = 1'b1;
        repeat (4) step();
        memop = 1'b0; memrd = 1'b0;
        step();
        idle();
        br = 1'b1;
        step();
        idle();

        // Saturation on the 4-bit counter, then clear
        memrd = 1'b1; idex_rt = 5'd3; rs = 5'd3; rs_used = 1'b1;
        repeat (20) step();
        check("sat", cntv[0], 32'd15);
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr", cntv[0], 32'd0);

        // Reset in the middle of a memory wait
        memop = 1'b1;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; memop = 1'b0;
        step();
        check("rst_frz", 32'(frz0), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rs      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            idex_rt = 5'($urandom_range(0, 3));
            rs_used = 1'($urandom_range(0, 1));
            rt_used = 1'($urandom_range(0, 1));
            memrd   = 1'($urandom_range(0, 1));
            memop   = ($urandom_range(0, 3) == 0);
            br      = ($urandom_range(0, 2) == 0);
            clr     = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
